// File: rtl/folding_sequencer_pkg.sv
// rtl/folding_sequencer_pkg.sv - shared types for the FFT input folding sequencer
package folding_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAIR = 2'd2
  } fold_seq_state_t;

endpackage

// File: rtl/folding_sequencer.sv
// rtl/folding_sequencer.sv - frame controller for the N-point input folding stage
module folding_sequencer
  import folding_sequencer_pkg::*;
#(
  parameter int N      = 8,
  parameter int FCNT_W = 8,
  localparam int CW    = $clog2(N),
  localparam int TW    = CW - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              flush,
  output logic              fold_enable,
  output logic              bfly_valid,
  output logic [TW-1:0]     twiddle_idx,
  output logic              pair_first,
  output logic              pair_last,
  output logic              frame_done,
  output logic              sop_err,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);

  localparam logic [CW-1:0] HALF_M1 = CW'(N / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [TW-1:0] K_LAST  = TW'(N / 2 - 1);

  fold_seq_state_t   r_state;
  fold_seq_state_t   w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              r_frame_done;
  logic              r_sop_err;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_fold_en;
  logic              w_bfly;
  logic [TW-1:0]     w_k;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
      r_sop_err    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_done_nxt;
      r_sop_err    <= w_err_nxt;
      if (w_done_nxt) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_fold_en   = 1'b0;
    w_bfly      = 1'b0;
    // In PAIR the counter's top bit is set, so its low bits are cnt - N/2.
    w_k         = (r_state == PAIR) ? r_cnt[TW-1:0] : '0;

    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (in_valid && in_sop) begin
      w_fold_en   = 1'b1;
      w_state_nxt = FILL;
      w_cnt_nxt   = CW'(1);
      w_err_nxt   = (r_state != IDLE);
    end else if (in_valid) begin
      case (r_state)
        FILL: begin
          w_fold_en = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == HALF_M1) begin
            w_state_nxt = PAIR;
          end
        end
        PAIR: begin
          w_fold_en = 1'b1;
          w_bfly    = 1'b1;
          if (r_cnt == LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        IDLE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign fold_enable = w_fold_en;
  assign bfly_valid  = w_bfly;
  assign twiddle_idx = w_k;
  assign pair_first  = w_bfly && (w_k == '0);
  assign pair_last   = w_bfly && (w_k == K_LAST);
  assign frame_done  = r_frame_done;
  assign sop_err     = r_sop_err;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_folding_sequencer.sv
// tb/tb_folding_sequencer.sv - directed self-checking bench for folding_sequencer
module tb_folding_sequencer;

  localparam int N      = 8;
  localparam int FCNT_W = 8;
  localparam int TW     = $clog2(N) - 1;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_sop;
  logic              flush;
  logic              fold_enable;
  logic              bfly_valid;
  logic [TW-1:0]     twiddle_idx;
  logic              pair_first;
  logic              pair_last;
  logic              frame_done;
  logic              sop_err;
  logic [FCNT_W-1:0] frame_cnt;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_fcnt = 0;

  logic          c_fe, c_bv, c_pf, c_pl;
  logic [TW-1:0] c_k;
  logic          r_fd, r_se;

  folding_sequencer #(.N(N), .FCNT_W(FCNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .flush       (flush),
    .fold_enable (fold_enable),
    .bfly_valid  (bfly_valid),
    .twiddle_idx (twiddle_idx),
    .pair_first  (pair_first),
    .pair_last   (pair_last),
    .frame_done  (frame_done),
    .sop_err     (sop_err),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; combinational outputs sampled at negedge, registered ones at next posedge+1.
  task automatic cyc(input logic v, input logic s, input logic f);
    in_valid = v;
    in_sop   = s;
    flush    = f;
    @(negedge clk);
    c_fe = fold_enable;
    c_bv = bfly_valid;
    c_k  = twiddle_idx;
    c_pf = pair_first;
    c_pl = pair_last;
    @(posedge clk);
    #1;
    r_fd = frame_done;
    r_se = sop_err;
  endtask

  task automatic frame_tail(input string tag, input int start);
    for (int i = start; i < N; i++) begin
      cyc(1'b1, i == 0, 1'b0);
      check({tag, "_fe"}, c_fe, 1);
      check({tag, "_bv"}, c_bv, i >= N / 2);
      check({tag, "_k"},  c_k,  (i >= N / 2) ? i - N / 2 : 0);
      check({tag, "_pf"}, c_pf, i == N / 2);
      check({tag, "_pl"}, c_pl, i == N - 1);
      check({tag, "_fd"}, r_fd, i == N - 1);
      check({tag, "_se"}, r_se, 0);
    end
    exp_fcnt = (exp_fcnt + 1) % (1 << FCNT_W);
    check({tag, "_fcnt"}, frame_cnt, exp_fcnt);
    check({tag, "_busy"}, busy, 0);
  endtask

  int done_cnt;
  int fe_cnt;
  int bv_cnt;
  int k_seen;

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    flush = 1'b0;
    #12;
    check("rst_fe", fold_enable, 0);
    check("rst_bv", bfly_valid, 0);
    check("rst_k", twiddle_idx, 0);
    check("rst_pf", pair_first, 0);
    check("rst_pl", pair_last, 0);
    check("rst_fd", frame_done, 0);
    check("rst_se", sop_err, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    #4 reset = 1'b1;
    @(posedge clk);
    #1;

    // sop without valid is ignored
    cyc(1'b0, 1'b1, 1'b0);
    check("novalid_fe", c_fe, 0);
    check("novalid_busy", busy, 0);

    frame_tail("single", 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("single_fd_clr", r_fd, 0);

    // stalls after samples 2 and 5
    begin
      int seq[12] = '{0, 1, 2, -1, -1, 3, 4, 5, -2, -2, 6, 7};
      done_cnt = 0;
      k_seen = 0;
      for (int j = 0; j < 12; j++) begin
        if (seq[j] >= 0) begin
          cyc(1'b1, seq[j] == 0, 1'b0);
          check("stall_fe", c_fe, 1);
          check("stall_bv", c_bv, seq[j] >= N / 2);
          if (seq[j] >= N / 2) begin
            check("stall_k", c_k, k_seen);
            k_seen++;
          end
        end else begin
          cyc(1'b0, 1'b0, 1'b0);
          check("gap_fe", c_fe, 0);
          check("gap_bv", c_bv, 0);
          check("gap_k", c_k, (seq[j] == -1) ? 0 : 2);
          check("gap_busy", busy, 1);
        end
        if (r_fd) done_cnt++;
      end
      cyc(1'b0, 1'b0, 1'b0);
      if (r_fd) done_cnt++;
      check("stall_done_cnt", done_cnt, 1);
      exp_fcnt++;
      check("stall_fcnt", frame_cnt, exp_fcnt);
    end

    // three back-to-back frames
    done_cnt = 0;
    fe_cnt = 0;
    bv_cnt = 0;
    for (int j = 0; j < 3 * N; j++) begin
      cyc(1'b1, (j % N) == 0, 1'b0);
      if (c_fe) fe_cnt++;
      if (c_bv) bv_cnt++;
      if (r_fd) done_cnt++;
    end
    exp_fcnt += 3;
    check("b2b_fe_cnt", fe_cnt, 3 * N);
    check("b2b_bv_cnt", bv_cnt, 3 * N / 2);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_fcnt", frame_cnt, exp_fcnt);

    // mid-frame sop on sample 5
    for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("mid_fe", c_fe, 1);
    check("mid_bv", c_bv, 0);
    check("mid_se", r_se, 1);
    check("mid_fd", r_fd, 0);
    check("mid_fcnt", frame_cnt, exp_fcnt);
    frame_tail("mid_new", 1);

    // sop on the last sample aborts the frame
    for (int i = 0; i < N - 1; i++) cyc(1'b1, i == 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("last_sop_bv", c_bv, 0);
    check("last_sop_pl", c_pl, 0);
    check("last_sop_se", r_se, 1);
    check("last_sop_fd", r_fd, 0);
    check("last_sop_fcnt", frame_cnt, exp_fcnt);
    frame_tail("last_sop_new", 1);

    // flush on sample 6
    for (int i = 0; i < 6; i++) cyc(1'b1, i == 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    check("flush_fe", c_fe, 0);
    check("flush_bv", c_bv, 0);
    check("flush_busy", busy, 0);
    check("flush_fd", r_fd, 0);
    check("flush_se", r_se, 0);
    check("flush_fcnt", frame_cnt, exp_fcnt);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check("drop_fe", c_fe, 0);
      check("drop_busy", busy, 0);
    end
    frame_tail("post_flush", 0);

    // async reset between edges in PAIR
    for (int i = 0; i < 6; i++) cyc(1'b1, i == 0, 1'b0);
    in_valid = 1'b1;
    in_sop = 1'b0;
    check("pre_arst_bv", bfly_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_fe", fold_enable, 0);
    check("arst_bv", bfly_valid, 0);
    check("arst_k", twiddle_idx, 0);
    check("arst_fd", frame_done, 0);
    check("arst_fcnt", frame_cnt, 0);
    check("arst_busy", busy, 0);
    #2 reset = 1'b1;
    exp_fcnt = 0;
    @(posedge clk);
    #1;

    // frame counter wrap
    for (int f = 0; f < (1 << FCNT_W) - 1; f++) begin
      for (int i = 0; i < N; i++) cyc(1'b1, i == 0, 1'b0);
    end
    exp_fcnt = (1 << FCNT_W) - 1;
    check("wrap_pre", frame_cnt, exp_fcnt);
    frame_tail("wrap", 0);

    in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
